// File: rtl/vect_mem_responder_pkg.sv
// Shared widths, transaction FSM state type and address range helper for the
// vector memory responder.
package vect_mem_responder_pkg;

  localparam int dwidth_int    = 32;
  localparam int dwidth_HBMadd = 32;
  localparam int dwidth_RFadd  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } txn_state_t;

  // True when no address bit at or above position aw is set.
  function automatic logic addr_fits(input logic [dwidth_HBMadd-1:0] addr, input int aw);
    return (addr >> aw) == {dwidth_HBMadd{1'b0}};
  endfunction

endpackage

// File: rtl/vect_mem_responder_rd_pipe.sv
// vect_rd_pipe: LAT-deep valid/data shift register for returning read data;
// en low freezes every stage, and each data stage only loads behind a valid beat.
module vect_rd_pipe #(
  parameter int LAT = 2,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] valid_r;
  logic [W-1:0]   data_r [LAT];

  // Shift stages forward on enabled cycles; data stages hold when no beat arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        data_r[i] <= {W{1'b0}};
      end
    end else if (en) begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[LAT-1];
  assign out_data  = data_r[LAT-1];

endmodule

// File: rtl/vect_mem_responder.sv
// HBM stand-in for the vector load/store path: word array, in-order fixed-latency
// reads, and a beat-counting transaction FSM. Optional macro: VECT_MEM_BOUNDS_CHECK_EN.
module vect_mem_responder
  import vect_mem_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     rd_req,
  input  logic [dwidth_HBMadd-1:0] rd_addr,
  input  logic                     wr_req,
  input  logic [dwidth_HBMadd-1:0] wr_addr,
  input  logic [dwidth_int-1:0]    wr_data,
  input  logic                     txn_start,
  input  logic [dwidth_RFadd-1:0]  txn_len,
  output logic                     rd_valid,
  output logic [dwidth_int-1:0]    rd_data,
  output logic                     busy,
  output logic                     txn_done,
  output logic                     addr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [dwidth_int-1:0]   mem [DEPTH];
  logic [AW-1:0]           rd_idx;
  logic [AW-1:0]           wr_idx;
  logic                    rd_ok;
  logic                    wr_ok;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    wr_commit;
  logic [dwidth_int-1:0]   rd_word;
  logic                    pipe_en;
  logic                    start_ok;
  logic                    beat_ok;
  txn_state_t              state_r;
  txn_state_t              state_n;
  logic [dwidth_RFadd-1:0] len_r;
  logic [dwidth_RFadd-1:0] len_n;
  logic [dwidth_RFadd-1:0] beat_r;
  logic [dwidth_RFadd-1:0] beat_n;

  assign rd_idx = rd_addr[AW-1:0];
  assign wr_idx = wr_addr[AW-1:0];

`ifdef VECT_MEM_BOUNDS_CHECK_EN
  assign rd_ok = addr_fits(rd_addr, AW);
  assign wr_ok = addr_fits(wr_addr, AW);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{rd_addr[dwidth_HBMadd-1:AW], wr_addr[dwidth_HBMadd-1:AW]};
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
`endif

  assign pipe_en   = !stall;
  assign rd_acc    = rd_req && !stall;
  assign wr_acc    = wr_req && !stall;
  assign wr_commit = wr_acc && wr_ok;

  // Read word selection: out-of-range reads return zero, same-index writes bypass the array
  always_comb begin
    rd_word = {dwidth_int{1'b0}};
    if (!rd_ok) begin
      rd_word = {dwidth_int{1'b0}};
    end else if (wr_commit && (wr_idx == rd_idx)) begin
      rd_word = wr_data;
    end else begin
      rd_word = mem[rd_idx];
    end
  end

  // Word array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_idx] <= wr_data;
    end
  end

  vect_rd_pipe #(
    .LAT (RD_LAT),
    .W   (dwidth_int)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pipe_en),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

  // A zero-length start never opens a transaction; stalled cycles neither start nor count
  assign start_ok = txn_start && (txn_len != {dwidth_RFadd{1'b0}}) && !stall;
  assign beat_ok  = rd_valid && !stall;

  // Transaction FSM next-state and done pulse; a start outranks a final beat
  always_comb begin
    state_n  = state_r;
    len_n    = len_r;
    beat_n   = beat_r;
    txn_done = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok) begin
          state_n = ACTIVE;
          len_n   = txn_len - dwidth_RFadd'(1);
          beat_n  = {dwidth_RFadd{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        if (start_ok) begin
          len_n  = txn_len - dwidth_RFadd'(1);
          beat_n = {dwidth_RFadd{1'b0}};
        end else if (beat_ok && (beat_r == len_r)) begin
          txn_done = 1'b1;
          state_n  = IDLE;
          beat_n   = {dwidth_RFadd{1'b0}};
        end else if (beat_ok) begin
          beat_n = beat_r + dwidth_RFadd'(1);
        end else begin
          beat_n = beat_r;
        end
      end
      default: begin
        state_n = IDLE;
        len_n   = {dwidth_RFadd{1'b0}};
        beat_n  = {dwidth_RFadd{1'b0}};
      end
    endcase
  end

  // FSM state, latched length and beat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      len_r   <= {dwidth_RFadd{1'b0}};
      beat_r  <= {dwidth_RFadd{1'b0}};
    end else begin
      state_r <= state_n;
      len_r   <= len_n;
      beat_r  <= beat_n;
    end
  end

  assign busy = (state_r == ACTIVE);

`ifdef VECT_MEM_BOUNDS_CHECK_EN
  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if ((rd_acc && !rd_ok) || (wr_acc && !wr_ok)) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_vect_mem_responder.sv
// Directed bench for vect_mem_responder: a queue/array model of the memory and
// transaction rules checked every cycle, plus pinned literal expectations.
module tb_vect_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
`ifdef VECT_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        txn_start;
  logic [7:0]  txn_len;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        txn_done;
  logic        addr_err;

  vect_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .txn_start (txn_start),
    .txn_len   (txn_len),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .txn_done  (txn_done),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: memory image, expected beats keyed by unstalled-cycle number
  typedef struct {
    int          due;
    logic [31:0] data;
  } beat_t;
  beat_t       exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          ucyc = 0;
  logic [31:0] last_d = 32'd0;
  logic        active_m = 1'b0;
  int          rem_m = 0;
  logic        err_m = 1'b0;
  logic        exp_v;
  logic [31:0] exp_d;
  logic        exp_done;
  logic        wr_eff_m;
  logic [31:0] rd_d_m;

  // Pinned literal expectations for the current cycle
  logic        pin_rd = 1'b0, pin_v = 1'b0;
  logic [31:0] pin_d = 32'd0;
  logic        pin_bd = 1'b0, pin_busy = 1'b0, pin_done = 1'b0;
  logic        pin_er = 1'b0, pin_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_rd_valid", rd_valid, 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_busy", busy, 32'd0);
      chk("reset_txn_done", txn_done, 32'd0);
      chk("reset_addr_err", addr_err, 32'd0);
      exp_q.delete();
      ucyc = 0; last_d = 32'd0; active_m = 1'b0; rem_m = 0; err_m = 1'b0;
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == ucyc);
      exp_d = exp_v ? exp_q[0].data : last_d;
      chk("rd_valid", rd_valid, exp_v);
      chk("rd_data", rd_data, exp_d);
      chk("busy", busy, active_m);
      chk("addr_err", addr_err, err_m);
      if (stall) begin
        chk("stall_txn_done", txn_done, 32'd0);
      end else begin
        if (exp_v) begin
          last_d = exp_q[0].data;
          void'(exp_q.pop_front());
        end
        exp_done = 1'b0;
        if (txn_start && txn_len != 8'd0) begin
          active_m = 1'b1;
          rem_m = txn_len;
        end else if (active_m && exp_v) begin
          rem_m--;
          if (rem_m == 0) begin
            exp_done = 1'b1;
            active_m = 1'b0;
          end
        end
        chk("txn_done", txn_done, exp_done);
        wr_eff_m = wr_req && (!BOUNDS || wr_addr < DEPTH);
        if (wr_req && BOUNDS && wr_addr >= DEPTH) err_m = 1'b1;
        if (rd_req) begin
          if (BOUNDS && rd_addr >= DEPTH) begin
            rd_d_m = 32'd0;
            err_m = 1'b1;
          end else if (wr_eff_m && (wr_addr % DEPTH) == (rd_addr % DEPTH)) begin
            rd_d_m = wr_data;
          end else begin
            rd_d_m = mem_m[rd_addr % DEPTH];
          end
          exp_q.push_back('{due: ucyc + RD_LAT, data: rd_d_m});
        end
        if (wr_eff_m) mem_m[wr_addr % DEPTH] = wr_data;
        ucyc++;
      end
      if (pin_rd) begin
        chk("pin_rd_valid", rd_valid, pin_v);
        if (pin_v) chk("pin_rd_data", rd_data, pin_d);
      end
      if (pin_bd) begin
        chk("pin_busy", busy, pin_busy);
        chk("pin_txn_done", txn_done, pin_done);
      end
      if (pin_er) chk("pin_addr_err", addr_err, pin_err);
    end
  end

  task automatic drive(input logic rq, input logic [31:0] ra, input logic wq,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input logic ts, input logic [7:0] tl, input logic st);
    rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
    txn_start = ts; txn_len = tl; stall = st;
    @(posedge clk);
    #1;
    pin_rd = 1'b0; pin_bd = 1'b0; pin_er = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic rd_start(input logic [31:0] a, input logic [7:0] l);
    drive(1'b1, a, 1'b0, 32'd0, 32'd0, 1'b1, l, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 32'd0, 1'b1, a, d, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic exp_rd(input logic v, input logic [31:0] d);
    pin_rd = 1'b1; pin_v = v; pin_d = d;
  endtask

  task automatic exp_bd(input logic b, input logic dn);
    pin_bd = 1'b1; pin_busy = b; pin_done = dn;
  endtask

  task automatic exp_err(input logic e);
    pin_er = 1'b1; pin_err = e;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; rd_req = 1'b0; rd_addr = 32'd0; wr_req = 1'b0;
    wr_addr = 32'd0; wr_data = 32'd0; txn_start = 1'b0; txn_len = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload words 0..15, then reset/latency check on addr 5
    for (int i = 0; i < 16; i++) wr(i, 32'h1000_0000 + i);
    wr(32'd5, 32'hA5A5_0001);
    rd(32'd5);
    exp_rd(1'b0, 32'd0); idle();
    exp_rd(1'b1, 32'hA5A5_0001); idle();
    idle();

    // Four-beat transaction
    rd_start(32'd0, 8'd4);
    rd(32'd1); rd(32'd2); rd(32'd3);
    exp_bd(1'b1, 1'b0); idle();
    exp_bd(1'b1, 1'b1); idle();
    exp_bd(1'b0, 1'b0); idle();

    // Stall for 3 cycles after the 2nd beat; reads offered under stall must be ignored
    rd_start(32'd0, 8'd4);
    rd(32'd1); rd(32'd2); rd(32'd3);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 1'b1);
    exp_rd(1'b1, 32'h1000_0002); exp_bd(1'b1, 1'b0); idle();
    exp_rd(1'b1, 32'h1000_0003); exp_bd(1'b1, 1'b1); idle();
    exp_bd(1'b0, 1'b0); idle();

    // Same-cycle write and read of index 7
    drive(1'b1, 32'd7, 1'b1, 32'd7, 32'h0000_1234, 1'b0, 8'd0, 1'b0);
    idle();
    exp_rd(1'b1, 32'h0000_1234); idle();
    rd(32'd7); idle();
    exp_rd(1'b1, 32'h0000_1234); idle();

    // Zero-length start is ignored; len=3 restarted with len=2 mid-flight
    drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 8'd0, 1'b0);
    exp_bd(1'b0, 1'b0); idle();
    rd_start(32'd0, 8'd3);
    rd(32'd1); rd(32'd2);
    drive(1'b1, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1, 8'd2, 1'b0);
    exp_bd(1'b1, 1'b0); rd(32'd4);
    exp_bd(1'b1, 1'b1); idle();
    exp_bd(1'b0, 1'b0); idle();

    // Out-of-range read of DEPTH+1 and write of 2*DEPTH+2
    rd(DEPTH + 1); idle();
    exp_rd(1'b1, BOUNDS ? 32'd0 : 32'h1000_0001); exp_err(BOUNDS); idle();
    exp_err(BOUNDS); idle();
    wr(2 * DEPTH + 2, 32'h0000_BEEF);
    rd(32'd2); idle();
    exp_rd(1'b1, BOUNDS ? 32'h1000_0002 : 32'h0000_BEEF); exp_err(BOUNDS); idle();

    // Asynchronous reset in the middle of a transaction
    rd_start(32'd0, 8'd4);
    rd(32'd1); rd(32'd2); rd(32'd3);
    rd_req = 1'b0; txn_start = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Array contents survive reset
    rd(32'd5); idle();
    exp_rd(1'b1, 32'hA5A5_0001); exp_bd(1'b0, 1'b0); idle();
    idle();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
